// File: rtl/bus_activity_monitor_pkg.sv
// Shared definitions for the bus activity monitor: FSM encoding and
// errorFlags bit positions.
package bus_activity_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  localparam int unsigned ERR_BUS      = 0;
  localparam int unsigned ERR_TIMEOUT  = 1;
  localparam int unsigned ERR_PROTOCOL = 2;

  localparam int unsigned WD_WIDTH = 16;

endpackage

// File: rtl/bus_activity_monitor_watchdog.sv
// Watchdog for an active bus transaction: counts enabled cycles and flags
// expiry when the count reaches TIMEOUT_CYCLES-1.
module watchdog_timer
  import bus_activity_monitor_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [WD_WIDTH-1:0] LIMIT = WD_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [WD_WIDTH-1:0] count_r;

  // Cycle counter; a clear (transaction start) wins over counting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = enable && (count_r == LIMIT);

endmodule

// File: rtl/bus_activity_monitor.sv
// Bus activity monitor: classifies each cycle as idle/transfer/wait, counts
// completed transactions and keeps sticky error flags.
module bus_activity_monitor
  import bus_activity_monitor_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   beginTransactionIn,
  input  logic                   endTransactionIn,
  input  logic                   dataValidIn,
  input  logic                   busErrorIn,
  input  logic                   clearErrors,
  output logic                   busIdle,
  output logic                   busTransfer,
  output logic                   busWait,
  output logic [COUNT_WIDTH-1:0] transactionCount,
  output logic [2:0]             errorFlags
);

  state_t                 state_r;
  state_t                 state_next_s;
  logic [2:0]             flag_set_s;
  logic                   count_inc_s;
  logic                   wd_clear_s;
  logic                   wd_enable_s;
  logic                   wd_expire_s;
  logic [2:0]             error_flags_r;
  logic [COUNT_WIDTH-1:0] transaction_count_r;

  watchdog_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock (clock),
    .reset (reset),
    .clear (wd_clear_s),
    .enable(wd_enable_s),
    .expire(wd_expire_s)
  );

  assign wd_enable_s = (state_r == ST_ACTIVE);

  // Next-state, flag-set and count-increment decode.
  always_comb begin
    state_next_s = state_r;
    flag_set_s   = 3'b000;
    count_inc_s  = 1'b0;
    wd_clear_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (endTransactionIn) begin
          flag_set_s[ERR_PROTOCOL] = 1'b1;
        end else begin
          flag_set_s[ERR_PROTOCOL] = 1'b0;
        end
        if (beginTransactionIn) begin
          state_next_s = ST_ACTIVE;
          wd_clear_s   = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        // An error aborts even when end or begin arrive in the same cycle.
        if (busErrorIn) begin
          state_next_s         = ST_IDLE;
          flag_set_s[ERR_BUS]  = 1'b1;
        end else if (endTransactionIn) begin
          count_inc_s = 1'b1;
          if (beginTransactionIn) begin
            state_next_s = ST_ACTIVE;
            wd_clear_s   = 1'b1;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          flag_set_s[ERR_PROTOCOL] = beginTransactionIn;
          if (wd_expire_s) begin
            state_next_s            = ST_TIMEOUT;
            flag_set_s[ERR_TIMEOUT] = 1'b1;
          end else begin
            state_next_s = ST_ACTIVE;
          end
        end
      end
      ST_TIMEOUT: begin
        state_next_s             = ST_IDLE;
        flag_set_s[ERR_PROTOCOL] = beginTransactionIn;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Sticky flags and completed-transaction count; clearErrors dominates.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      error_flags_r       <= 3'b000;
      transaction_count_r <= '0;
    end else if (clearErrors) begin
      error_flags_r       <= 3'b000;
      transaction_count_r <= '0;
    end else begin
      error_flags_r <= error_flags_r | flag_set_s;
      if (count_inc_s) begin
        transaction_count_r <= transaction_count_r + COUNT_WIDTH'(1);
      end else begin
        transaction_count_r <= transaction_count_r;
      end
    end
  end

  assign busIdle          = (state_r == ST_IDLE) && !beginTransactionIn;
  assign busTransfer      = dataValidIn && (state_r == ST_ACTIVE);
  assign busWait          = !dataValidIn && (state_r == ST_ACTIVE);
  assign transactionCount = transaction_count_r;
  assign errorFlags       = error_flags_r;

endmodule

// File: tb/tb_bus_activity_monitor.sv
// Directed, table-driven bench for bus_activity_monitor with hand sequences
// for watchdog timeout, count wrap and mid-transaction reset.
module tb_bus_activity_monitor;

  localparam int T  = 8;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          beginTransactionIn, endTransactionIn, dataValidIn, busErrorIn, clearErrors;
  logic          busIdle, busTransfer, busWait;
  logic [CW-1:0] transactionCount;
  logic [2:0]    errorFlags;

  int n_cmp = 0;
  int n_bad = 0;

  bus_activity_monitor #(.TIMEOUT_CYCLES(T), .COUNT_WIDTH(CW)) dut (
    .clock             (clock),
    .reset             (reset),
    .beginTransactionIn(beginTransactionIn),
    .endTransactionIn  (endTransactionIn),
    .dataValidIn       (dataValidIn),
    .busErrorIn        (busErrorIn),
    .clearErrors       (clearErrors),
    .busIdle           (busIdle),
    .busTransfer       (busTransfer),
    .busWait           (busWait),
    .transactionCount  (transactionCount),
    .errorFlags        (errorFlags)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       b, e, d, r, c;
    logic       ei, ex, ew;
    logic [7:0] ec;
    logic [2:0] ef;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t v(input logic b, e, d, r, c, ei, ex, ew,
                             input logic [7:0] ec, input logic [2:0] ef);
    vec_t x;
    x.b = b; x.e = e; x.d = d; x.r = r; x.c = c;
    x.ei = ei; x.ex = ex; x.ew = ew; x.ec = ec; x.ef = ef;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic b, e, d, r, c);
    beginTransactionIn = b;
    endTransactionIn   = e;
    dataValidIn        = d;
    busErrorIn         = r;
    clearErrors        = c;
  endtask

  task automatic check_all(input string tag, input logic ei, ex, ew,
                           input logic [7:0] ec, input logic [2:0] ef);
    check({tag, " idle"},  32'(busIdle), 32'(ei));
    check({tag, " xfer"},  32'(busTransfer), 32'(ex));
    check({tag, " wait"},  32'(busWait), 32'(ew));
    check({tag, " count"}, 32'(transactionCount), 32'(ec));
    check({tag, " flags"}, 32'(errorFlags), 32'(ef));
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    //           b     e     d     r     c     idle  xfer  wait  count  flags
    vecs[0]  = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3'b000);
    vecs[1]  = v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'b000);
    vecs[2]  = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 3'b000);
    vecs[3]  = v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 3'b000);
    vecs[4]  = v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 3'b000);
    vecs[5]  = v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 3'b000);
    vecs[6]  = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 3'b000);
    vecs[7]  = v(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 3'b000);
    vecs[8]  = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 3'b000);
    vecs[9]  = v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 3'b000);
    vecs[10] = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 3'b100);
    vecs[11] = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 3'b100);
    vecs[12] = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3'b000);
    vecs[13] = v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'b000);
    vecs[14] = v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 3'b000);
    vecs[15] = v(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 3'b000);
    vecs[16] = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3'b001);
    vecs[17] = v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'b001);
    vecs[18] = v(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 3'b001);
    vecs[19] = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 3'b001);
    vecs[20] = v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 3'b001);
    vecs[21] = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 3'b001);
    vecs[22] = v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 3'b001);
    vecs[23] = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 3'b001);
    vecs[24] = v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 3'b001);
    vecs[25] = v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 3'b001);
    vecs[26] = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 3'b101);
    vecs[27] = v(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 3'b101);
    vecs[28] = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3'b000);

    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    @(negedge clock);
    check_all("reset", 1'b1, 1'b0, 1'b0, 8'd0, 3'b000);
    next_cycle();
    reset = 1'b1;

    for (int i = 0; i < 29; i++) begin
      drive(vecs[i].b, vecs[i].e, vecs[i].d, vecs[i].r, vecs[i].c);
      @(negedge clock);
      check_all($sformatf("vec%0d", i), vecs[i].ei, vecs[i].ex, vecs[i].ew, vecs[i].ec, vecs[i].ef);
      next_cycle();
    end

    // Watchdog: begin-in-ACTIVE and data beats do not restart it; a back-to-back begin does.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      drive((k == 2), 1'b0, k[0], 1'b0, 1'b0);
      @(negedge clock);
      check($sformatf("wd pre%0d active", k), 32'(busTransfer | busWait), 32'd1);
      next_cycle();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    for (int k = 0; k < T; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, (k == 0));
      @(negedge clock);
      check($sformatf("wd post%0d xfer", k), 32'(busTransfer), 32'd1);
      next_cycle();
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    check_all("timeout", 1'b0, 1'b0, 1'b0, 8'd0, 3'b010);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    check_all("after timeout", 1'b1, 1'b0, 1'b0, 8'd0, 3'b110);
    next_cycle();

    // Count wrap: 2^CW back-to-back transactions.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    for (int k = 0; k < 255; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    check_all("count max", 1'b0, 1'b0, 1'b1, 8'hFF, 3'b000);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    check_all("count wrap", 1'b1, 1'b0, 1'b0, 8'd0, 3'b000);
    next_cycle();

    // Reset mid-transaction with nonzero count and flags.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    check_all("pre reset", 1'b0, 1'b1, 1'b0, 8'd1, 3'b100);
    next_cycle();
    #1;
    reset = 1'b0;
    #1;
    check_all("mid reset", 1'b1, 1'b0, 1'b0, 8'd0, 3'b000);
    @(negedge clock);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    @(negedge clock);
    check_all("post reset", 1'b1, 1'b0, 1'b0, 8'd0, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_activity_monitor.md
BUS_ACTIVITY_MONITOR -- requirements
Module: bus_activity_monitor

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the number of active cycles without end/error before the watchdog fires (range 2..65535).
REQ-002 SHALL have parameter COUNT_WIDTH, default 16, meaning the width of the transaction counter.
REQ-003 SHALL have port clock  in  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port beginTransactionIn  in  1  bus transaction start strobe.
REQ-006 SHALL have port endTransactionIn  in  1  bus transaction end strobe.
REQ-007 SHALL have port dataValidIn  in  1  data beat on the bus this cycle.
REQ-008 SHALL have port busErrorIn  in  1  bus error; aborts the transaction.
REQ-009 SHALL have port clearErrors  in  1  synchronous clear of the sticky error flags and transactionCount.
REQ-010 SHALL have port busIdle  out  1  no transaction in progress; feeds the profile bus-idle counter.
REQ-011 SHALL have port busTransfer  out  1  data beat inside an active transaction.
REQ-012 SHALL have port busWait  out  1  active transaction with no data beat this cycle.
REQ-013 SHALL have port transactionCount  out  COUNT_WIDTH  number of completed transactions.
REQ-014 SHALL have port errorFlags  out  3  sticky flags: [0] bus error, [1] watchdog timeout, [2] protocol violation.

Function
REQ-015 SHALL implement an FSM with states IDLE, ACTIVE and TIMEOUT.
REQ-016 IDLE SHALL go to ACTIVE on beginTransactionIn and otherwise stay in IDLE.
REQ-017 ACTIVE SHALL go to IDLE on endTransactionIn or busErrorIn, and SHALL stay in ACTIVE when beginTransactionIn is also high in that cycle (back-to-back transaction).
REQ-018 ACTIVE SHALL go to TIMEOUT when the watchdog reaches TIMEOUT_CYCLES-1 with no end or error in that cycle.
REQ-019 TIMEOUT SHALL last exactly one cycle and then return to IDLE; beginTransactionIn during TIMEOUT SHALL be ignored and set errorFlags[2].
REQ-020 The watchdog counter SHALL be 16 bits, SHALL clear on every entry to ACTIVE (including back-to-back), and SHALL increment each ACTIVE cycle; dataValidIn SHALL NOT restart it.
REQ-021 busIdle SHALL be combinational: 1 exactly when state is IDLE and beginTransactionIn is 0, so it is 0 in the begin cycle.
REQ-022 busTransfer SHALL equal dataValidIn & (state==ACTIVE).
REQ-023 busWait SHALL equal ~dataValidIn & (state==ACTIVE).
REQ-024 In TIMEOUT, busIdle, busTransfer and busWait SHALL all be 0.
REQ-025 transactionCount SHALL increment by 1 on each ACTIVE cycle with endTransactionIn and no busErrorIn, and SHALL wrap from all-ones to 0.
REQ-026 busErrorIn in ACTIVE SHALL set errorFlags[0], SHALL return to IDLE and SHALL NOT increment transactionCount, even if endTransactionIn is high in the same cycle.
REQ-027 Entry to TIMEOUT SHALL set errorFlags[1].
REQ-028 errorFlags[2] SHALL be set by beginTransactionIn in ACTIVE without endTransactionIn or busErrorIn in the same cycle; the FSM SHALL stay in ACTIVE and SHALL NOT restart the watchdog.
REQ-029 errorFlags[2] SHALL also be set by endTransactionIn in IDLE.
REQ-030 dataValidIn or busErrorIn in IDLE SHALL be ignored, with no flag set.
REQ-031 clearErrors SHALL zero errorFlags and transactionCount on the next edge, and SHALL take priority over any set or increment in the same cycle.
REQ-032 All flag and count updates SHALL be visible on outputs one cycle after the causing edge.

Reset
REQ-033 While reset is low, state SHALL be IDLE, the watchdog 0, transactionCount 0 and errorFlags 0, so busIdle=1, busTransfer=0 and busWait=0.
REQ-034 Reset asserted mid-transaction SHALL abort it immediately, with no count increment and no flag set.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, ACTIVE=2'd1, TIMEOUT=2'd2) and the errorFlags bit-index constants.
REQ-036 The watchdog SHALL be implemented as one sub-module, watchdog_timer (load-clear, enable, expire output); the rest SHALL be flat.

Verification
REQ-037 Reset release, begin at cycle 5, dataValidIn on cycles 7-10, end at cycle 12 -> busIdle=0 for cycles 5-12; busTransfer=1 on cycles 7-10; busWait=1 on cycles 6, 11 and 12; transactionCount=1 from cycle 13.
REQ-038 TIMEOUT_CYCLES=8, begin with no end -> TIMEOUT entered 8 cycles after begin, errorFlags=3'b010, IDLE one cycle later, transactionCount unchanged.
REQ-039 end+begin in the same ACTIVE cycle, second transaction ends 3 cycles later -> busIdle never 1 between the transactions; transactionCount +2; watchdog restarted.
REQ-040 busErrorIn together with endTransactionIn -> errorFlags[0]=1, count unchanged, IDLE; clearErrors plus a completing end in the same cycle -> flags=0, count=0.
REQ-041 transactionCount preset to 16'hFFFF by 65535 transactions, one more -> 0; begin while ACTIVE -> errorFlags[2]=1, state ACTIVE.
REQ-042 reset pulled low mid-transaction -> busIdle=1 immediately, all outputs at reset values.
